mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have upstream inputs: valid_in 1; pc_in 32; opcode_in 7; funct3_in 3; rd_in 5; alu_res_in 32 (effective address or result); reg_2_in 32 (store data).
REQ-003 SHALL have stall  out  1: upstream holds all inputs stable while it is high.
REQ-004 SHALL have data-memory ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32 (word-aligned); dmem_be out 4; dmem_wdata out 32; dmem_ack in 1; dmem_rdata in 32.
REQ-005 SHALL have writeback outputs: valid_out 1; pc_out 32; rd_out 5; wb_data_out 32; reg_write_out 1; fault_out 1 (misaligned or illegal-width access).
REQ-006 SHALL use parameters: LOAD_OP, default 7'b0000011, load opcode; STORE_OP, default 7'b0100011, store opcode.

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-008 SHALL treat a memory op as valid_in=1 with opcode LOAD_OP or STORE_OP.
REQ-009 SHALL, in IDLE with a valid non-memory op, register outputs at the next edge: valid_out=1, wb_data_out=alu_res_in, pc_out, rd_out copied; 1-cycle latency; stall=0.
REQ-010 SHALL set reg_write_out=1 only for a valid load or non-memory op with rd!=0, excluding STORE_OP and branch opcode 7'b1100011, and never when fault_out=1.
REQ-011 SHALL flag fault when halfword access has addr[0]=1, word access has addr[1:0]!=0, or funct3 is not in {000,001,010,100,101} (loads) / {000,001,010} (stores).
REQ-012 SHALL, for a faulting memory op in IDLE, issue no memory request; next edge: valid_out=1, fault_out=1, reg_write_out=0; stall=0.
REQ-013 SHALL, in IDLE with a valid non-faulting memory op, assert stall combinationally, capture address, offset, funct3, rd, pc, store data into internal registers, and go to ACCESS.
REQ-014 SHALL, in ACCESS, drive dmem_req=1 and stall=1, with dmem_we/addr/be/wdata from captured values held stable until dmem_ack.
REQ-015 SHALL, on dmem_ack in ACCESS, register writeback outputs (valid_out=1) at that edge and go to DONE; an ACCESS with no ack waits indefinitely.
REQ-016 SHALL, in DONE, drive stall=0 and dmem_req=0, ignore inputs (already consumed), register valid_out=0 at the next edge, and return to IDLE.
REQ-017 SHALL ignore dmem_ack outside ACCESS.
REQ-018 SHALL drive dmem_addr={addr[31:2],2'b00}.
REQ-019 SHALL, for stores, drive SB: be=1<<addr[1:0], wdata={4{data[7:0]}}; SH: be=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}; SW: be=4'b1111, wdata=data.
REQ-020 SHALL, for loads, select the byte/half of dmem_rdata by offset; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through; dmem_we=0, be=4'b1111.
REQ-021 SHALL, for a completed store, output valid_out=1, reg_write_out=0, wb_data_out=0.
REQ-022 SHALL drive valid_out=0, reg_write_out=0, fault_out=0 in any cycle following an edge with no retiring instruction.

Reset
REQ-023 SHALL, on reset, set state IDLE and all registered outputs and internal captures to 0.
REQ-024 SHALL, on reset mid-ACCESS, abandon the access: dmem_req=0 from the cycle after the reset edge; no writeback produced.
REQ-025 SHALL give reset priority over dmem_ack and valid_in in the same cycle.

Structure
REQ-026 SHALL place opcode constants, load/store funct3 encodings and FSM state encoding in a shared package.
REQ-027 SHALL implement load extraction/extension (REQ-020) as a combinational sub-module mem_load_format.

Verification
REQ-028 ALU op: valid_in=1, opcode 0110011, rd=5, alu_res=0x1234 -> next cycle valid_out=1, wb_data_out=0x1234, reg_write_out=1, stall never high.
REQ-029 LB at addr 0x1003, dmem_rdata=0x80FFFFFF, ack after 3 ACCESS cycles -> stall high 4 cycles, dmem_addr=0x1000, wb_data_out=0xFFFFFF80.
REQ-030 SH at addr 0x2002, reg_2=0x0000BEEF -> dmem_we=1, be=4'b1100, wdata=0xBEEFBEEF; retire with reg_write_out=0.
REQ-031 LW at addr 0x3001 -> no dmem_req, next cycle fault_out=1, reg_write_out=0, valid_out=1.
REQ-032 Reset asserted during ACCESS with ack same cycle -> no valid_out, dmem_req=0 after edge, state IDLE.
REQ-033 Back-to-back LW then ADD: LW retires, DONE cycle stall=0, ADD retires two cycles after LW retire; LW not reissued.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: opcodes, load/store funct3 values,
// FSM states and the alignment/width legality check.
package mem_access_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Returns 1 when the access is misaligned or uses a width code the op cannot take.
    function automatic logic access_fault(input logic is_store, input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic ok;
        case (funct3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = ~offset[0];
            F3_LW:   ok = (offset == 2'b00);
            F3_LBU:  ok = ~is_store;
            F3_LHU:  ok = ~is_store & ~offset[0];
            default: ok = 1'b0;
        endcase
        return ~ok;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_load_format.sv
// Picks the addressed byte/halfword out of a read word and extends it per the load width.
module mem_load_format
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic        [7:0]  byte_sel;
    logic        [15:0] half_sel;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_sext;
    logic signed [31:0] half_sext;

    always_comb begin
        byte_sel  = rdata[{offset, 3'b000} +: 8];
        half_sel  = offset[1] ? rdata[31:16] : rdata[15:0];
        byte_s    = signed'(byte_sel);
        half_s    = signed'(half_sel);
        byte_sext = byte_s;
        half_sext = half_s;
        case (funct3)
            F3_LB:   data = byte_sext;
            F3_LH:   data = half_sext;
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through in one cycle and runs
// loads/stores over a req/ack data-memory bus, stalling upstream while the access is open.
module mem_access
    import mem_access_pkg::*;
#(
    parameter logic [6:0] LOAD_OP  = OP_LOAD,
    parameter logic [6:0] STORE_OP = OP_STORE
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [6:0]  opcode_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] reg_2_in,
    output logic        stall,

    mem_access_if.master dmem,

    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [4:0]  rd_out,
    output logic [31:0] wb_data_out,
    output logic        reg_write_out,
    output logic        fault_out
);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] data_q, data_d;
    logic        is_store_q, is_store_d;

    logic        valid_out_q, valid_out_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        reg_write_q, reg_write_d;
    logic        fault_q, fault_d;

    logic        is_load_in, is_store_in, is_mem_in, fault_in;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] load_data;

    mem_load_format u_load_format (
        .rdata  (dmem.dmem_rdata),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    // Byte lanes and replicated write data come from the captured request only.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                store_be    = 4'b0001 << addr_q[1:0];
                store_wdata = {4{data_q[7:0]}};
            end
            2'b01: begin
                store_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{data_q[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = data_q;
            end
        endcase
    end

    always_comb begin
        is_load_in  = valid_in && (opcode_in == LOAD_OP);
        is_store_in = valid_in && (opcode_in == STORE_OP);
        is_mem_in   = is_load_in || is_store_in;
        fault_in    = is_mem_in && access_fault(is_store_in, funct3_in, alu_res_in[1:0]);

        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        pc_d        = pc_q;
        data_d      = data_q;
        is_store_d  = is_store_q;
        valid_out_d = 1'b0;
        reg_write_d = 1'b0;
        fault_d     = 1'b0;
        pc_out_d    = pc_out_q;
        rd_out_d    = rd_out_q;
        wb_data_d   = wb_data_q;
        stall       = 1'b0;
        dmem.dmem_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_in && !is_mem_in) begin
                    valid_out_d = 1'b1;
                    pc_out_d    = pc_in;
                    rd_out_d    = rd_in;
                    wb_data_d   = alu_res_in;
                    reg_write_d = (rd_in != 5'd0) && (opcode_in != OP_BRANCH);
                end else if (fault_in) begin
                    valid_out_d = 1'b1;
                    fault_d     = 1'b1;
                    pc_out_d    = pc_in;
                    rd_out_d    = rd_in;
                    wb_data_d   = 32'h0;
                end else if (is_mem_in) begin
                    stall      = 1'b1;
                    addr_d     = alu_res_in;
                    funct3_d   = funct3_in;
                    rd_d       = rd_in;
                    pc_d       = pc_in;
                    data_d     = reg_2_in;
                    is_store_d = is_store_in;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                stall         = 1'b1;
                dmem.dmem_req = 1'b1;
                if (dmem.dmem_ack) begin
                    valid_out_d = 1'b1;
                    pc_out_d    = pc_q;
                    rd_out_d    = rd_q;
                    wb_data_d   = is_store_q ? 32'h0 : load_data;
                    reg_write_d = !is_store_q && (rd_q != 5'd0);
                    state_d     = ST_DONE;
                end
            end
            // Upstream is released here; whatever it still presents was already consumed.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'h0;
            funct3_q    <= 3'h0;
            rd_q        <= 5'h0;
            pc_q        <= 32'h0;
            data_q      <= 32'h0;
            is_store_q  <= 1'b0;
            valid_out_q <= 1'b0;
            pc_out_q    <= 32'h0;
            rd_out_q    <= 5'h0;
            wb_data_q   <= 32'h0;
            reg_write_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            pc_q        <= pc_d;
            data_q      <= data_d;
            is_store_q  <= is_store_d;
            valid_out_q <= valid_out_d;
            pc_out_q    <= pc_out_d;
            rd_out_q    <= rd_out_d;
            wb_data_q   <= wb_data_d;
            reg_write_q <= reg_write_d;
            fault_q     <= fault_d;
        end
    end

    assign dmem.dmem_we    = (state_q == ST_ACCESS) && is_store_q;
    assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem.dmem_be    = is_store_q ? store_be : 4'b1111;
    assign dmem.dmem_wdata = store_wdata;

    assign valid_out     = valid_out_q;
    assign pc_out        = pc_out_q;
    assign rd_out        = rd_out_q;
    assign wb_data_out   = wb_data_q;
    assign reg_write_out = reg_write_q;
    assign fault_out     = fault_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a vector table of single instructions plus
// hand-written reset-during-access, back-to-back and stray-ack sequences.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] pc_in;
    logic [6:0]  opcode_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_in;
    logic [31:0] alu_res_in;
    logic [31:0] reg_2_in;
    logic        stall;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [4:0]  rd_out;
    logic [31:0] wb_data_out;
    logic        reg_write_out;
    logic        fault_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_access_if dmem ();

    mem_access dut (
        .clock         (clock),
        .reset         (reset),
        .valid_in      (valid_in),
        .pc_in         (pc_in),
        .opcode_in     (opcode_in),
        .funct3_in     (funct3_in),
        .rd_in         (rd_in),
        .alu_res_in    (alu_res_in),
        .reg_2_in      (reg_2_in),
        .stall         (stall),
        .dmem          (dmem),
        .valid_out     (valid_out),
        .pc_out        (pc_out),
        .rd_out        (rd_out),
        .wb_data_out   (wb_data_out),
        .reg_write_out (reg_write_out),
        .fault_out     (fault_out)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] reg2;
        logic [31:0] rdata;
        int          ack_after;
        logic        e_fault;
        logic        e_rw;
        logic [31:0] e_wb;
        int          e_stall;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    localparam logic [6:0] OP_ALU = 7'b0110011;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                input logic [31:0] alu, input logic [31:0] reg2,
                                input logic [31:0] rdata, input int ack_after,
                                input logic e_fault, input logic e_rw, input logic [31:0] e_wb,
                                input int e_stall, input logic e_req, input logic e_we,
                                input logic [3:0] e_be, input logic [31:0] e_addr,
                                input logic [31:0] e_wdata);
        vec_t v;
        v.op = op; v.f3 = f3; v.rd = rd; v.alu = alu; v.reg2 = reg2; v.rdata = rdata;
        v.ack_after = ack_after; v.e_fault = e_fault; v.e_rw = e_rw; v.e_wb = e_wb;
        v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we; v.e_be = e_be;
        v.e_addr = e_addr; v.e_wdata = e_wdata;
        return v;
    endfunction

    // Presents one instruction just after a rising edge, answers the memory request,
    // and checks retirement, bus values and the following idle cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int stall_cnt = 0;
        int acc_cnt   = 0;
        bit done      = 0;
        logic [31:0] pc_exp = 32'h100 + 32'(idx * 4);
        valid_in   = 1'b1;
        pc_in      = pc_exp;
        opcode_in  = v.op;
        funct3_in  = v.f3;
        rd_in      = v.rd;
        alu_res_in = v.alu;
        reg_2_in   = v.reg2;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clock);
            if (stall) stall_cnt++;
            if (dmem.dmem_req) begin
                acc_cnt++;
                if (acc_cnt == 1) begin
                    check($sformatf("v%0d_addr", idx), dmem.dmem_addr, v.e_addr);
                    check($sformatf("v%0d_we", idx), 32'(dmem.dmem_we), 32'(v.e_we));
                    check($sformatf("v%0d_be", idx), 32'(dmem.dmem_be), 32'(v.e_be));
                    if (v.e_we)
                        check($sformatf("v%0d_wdata", idx), dmem.dmem_wdata, v.e_wdata);
                end
                if (acc_cnt >= v.ack_after) begin
                    dmem.dmem_ack   = 1'b1;
                    dmem.dmem_rdata = v.rdata;
                end
            end
            @(posedge clock);
            #1;
            dmem.dmem_ack   = 1'b0;
            dmem.dmem_rdata = 32'h0;
            if (valid_out) done = 1;
        end
        valid_in = 1'b0;
        check($sformatf("v%0d_retired", idx), 32'(done), 32'd1);
        check($sformatf("v%0d_fault", idx), 32'(fault_out), 32'(v.e_fault));
        check($sformatf("v%0d_reg_write", idx), 32'(reg_write_out), 32'(v.e_rw));
        check($sformatf("v%0d_pc", idx), pc_out, pc_exp);
        check($sformatf("v%0d_rd", idx), 32'(rd_out), 32'(v.rd));
        if (!v.e_fault)
            check($sformatf("v%0d_wb", idx), wb_data_out, v.e_wb);
        check($sformatf("v%0d_stall_cycles", idx), 32'(stall_cnt), 32'(v.e_stall));
        check($sformatf("v%0d_req_seen", idx), 32'(acc_cnt != 0), 32'(v.e_req));
        @(negedge clock);
        check($sformatf("v%0d_post_stall", idx), 32'(stall), 32'd0);
        check($sformatf("v%0d_post_req", idx), 32'(dmem.dmem_req), 32'd0);
        @(posedge clock);
        #1;
        check($sformatf("v%0d_post_valid", idx), 32'(valid_out), 32'd0);
        check($sformatf("v%0d_post_rw", idx), 32'(reg_write_out), 32'd0);
        check($sformatf("v%0d_post_fault", idx), 32'(fault_out), 32'd0);
    endtask

    initial begin
        //            op        f3      rd     alu            reg2           rdata          ack flt rw  wb             stl req we  be       addr           wdata
        vecs[0]  = mk(OP_ALU,   3'b000, 5'd5,  32'h0000_1234, 32'h0,         32'h0,         1, 0, 1, 32'h0000_1234, 0, 0, 0, 4'h0,    32'h0,         32'h0);
        vecs[1]  = mk(OP_LOAD,  F3_LB,  5'd1,  32'h0000_1003, 32'h0,         32'h80FF_FFFF, 3, 0, 1, 32'hFFFF_FF80, 4, 1, 0, 4'b1111, 32'h0000_1000, 32'h0);
        vecs[2]  = mk(OP_STORE, F3_SH,  5'd7,  32'h0000_2002, 32'h0000_BEEF, 32'h0,         1, 0, 0, 32'h0,         2, 1, 1, 4'b1100, 32'h0000_2000, 32'hBEEF_BEEF);
        vecs[3]  = mk(OP_LOAD,  F3_LW,  5'd3,  32'h0000_3001, 32'h0,         32'h0,         1, 1, 0, 32'h0,         0, 0, 0, 4'h0,    32'h0,         32'h0);
        vecs[4]  = mk(OP_LOAD,  F3_LBU, 5'd2,  32'h0000_1002, 32'h0,         32'h1234_5678, 1, 0, 1, 32'h0000_0034, 2, 1, 0, 4'b1111, 32'h0000_1000, 32'h0);
        vecs[5]  = mk(OP_LOAD,  F3_LH,  5'd4,  32'h0000_1002, 32'h0,         32'h8001_7FFF, 1, 0, 1, 32'hFFFF_8001, 2, 1, 0, 4'b1111, 32'h0000_1000, 32'h0);
        vecs[6]  = mk(OP_LOAD,  F3_LHU, 5'd6,  32'h0000_1000, 32'h0,         32'h8001_F00D, 1, 0, 1, 32'h0000_F00D, 2, 1, 0, 4'b1111, 32'h0000_1000, 32'h0);
        vecs[7]  = mk(OP_LOAD,  F3_LW,  5'd8,  32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 2, 0, 1, 32'hDEAD_BEEF, 3, 1, 0, 4'b1111, 32'h0000_1004, 32'h0);
        vecs[8]  = mk(OP_STORE, F3_SB,  5'd0,  32'h0000_2001, 32'h1234_56A5, 32'h0,         1, 0, 0, 32'h0,         2, 1, 1, 4'b0010, 32'h0000_2000, 32'hA5A5_A5A5);
        vecs[9]  = mk(OP_STORE, F3_SW,  5'd9,  32'h0000_2008, 32'hCAFE_F00D, 32'h0,         1, 0, 0, 32'h0,         2, 1, 1, 4'b1111, 32'h0000_2008, 32'hCAFE_F00D);
        vecs[10] = mk(OP_STORE, F3_SH,  5'd1,  32'h0000_2001, 32'h0000_1111, 32'h0,         1, 1, 0, 32'h0,         0, 0, 0, 4'h0,    32'h0,         32'h0);
        vecs[11] = mk(OP_LOAD,  3'b011, 5'd1,  32'h0000_1000, 32'h0,         32'h0,         1, 1, 0, 32'h0,         0, 0, 0, 4'h0,    32'h0,         32'h0);
        vecs[12] = mk(OP_STORE, 3'b100, 5'd1,  32'h0000_2000, 32'h0,         32'h0,         1, 1, 0, 32'h0,         0, 0, 0, 4'h0,    32'h0,         32'h0);
        vecs[13] = mk(OP_BRANCH,3'b000, 5'd3,  32'h0000_0055, 32'h0,         32'h0,         1, 0, 0, 32'h0000_0055, 0, 0, 0, 4'h0,    32'h0,         32'h0);
        vecs[14] = mk(OP_ALU,   3'b000, 5'd0,  32'h0000_0099, 32'h0,         32'h0,         1, 0, 0, 32'h0000_0099, 0, 0, 0, 4'h0,    32'h0,         32'h0);
        vecs[15] = mk(OP_LOAD,  F3_LW,  5'd0,  32'h0000_1008, 32'h0,         32'h1111_2222, 1, 0, 0, 32'h1111_2222, 2, 1, 0, 4'b1111, 32'h0000_1008, 32'h0);
        vecs[16] = mk(OP_LOAD,  F3_LH,  5'd2,  32'h0000_1001, 32'h0,         32'h0,         1, 1, 0, 32'h0,         0, 0, 0, 4'h0,    32'h0,         32'h0);

        reset = 1'b1; valid_in = 1'b0; pc_in = 32'h0; opcode_in = 7'h0; funct3_in = 3'h0;
        rd_in = 5'h0; alu_res_in = 32'h0; reg_2_in = 32'h0;
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_rw", 32'(reg_write_out), 32'd0);
        check("rst_fault", 32'(fault_out), 32'd0);
        check("rst_wb", wb_data_out, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_req", 32'(dmem.dmem_req), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // Reset lands in ACCESS together with an ack: the access is abandoned.
        valid_in = 1'b1; pc_in = 32'h300; opcode_in = OP_LOAD; funct3_in = F3_LW;
        rd_in = 5'd9; alu_res_in = 32'h0000_1000; reg_2_in = 32'h0;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("rsta_req_before", 32'(dmem.dmem_req), 32'd1);
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h1234_5678; reset = 1'b1;
        @(posedge clock);
        #1;
        dmem.dmem_ack = 1'b0; reset = 1'b0; valid_in = 1'b0;
        check("rsta_valid", 32'(valid_out), 32'd0);
        check("rsta_req_after", 32'(dmem.dmem_req), 32'd0);
        check("rsta_state", 32'(dut.state_q), 32'(ST_IDLE));
        @(posedge clock);
        #1;
        check("rsta_valid_later", 32'(valid_out), 32'd0);

        // Stray ack while idle changes nothing.
        @(negedge clock);
        dmem.dmem_ack = 1'b1;
        @(posedge clock);
        #1;
        dmem.dmem_ack = 1'b0;
        check("stray_ack_valid", 32'(valid_out), 32'd0);
        check("stray_ack_state", 32'(dut.state_q), 32'(ST_IDLE));

        // LW followed directly by ADD.
        valid_in = 1'b1; pc_in = 32'h400; opcode_in = OP_LOAD; funct3_in = F3_LW;
        rd_in = 5'd2; alu_res_in = 32'h0000_1000; reg_2_in = 32'h0;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("b2b_req", 32'(dmem.dmem_req), 32'd1);
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hA5A5_0001;
        @(posedge clock);
        #1;
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 32'h0;
        check("b2b_lw_valid", 32'(valid_out), 32'd1);
        check("b2b_lw_wb", wb_data_out, 32'hA5A5_0001);
        check("b2b_lw_pc", pc_out, 32'h400);
        @(negedge clock);
        check("b2b_done_stall", 32'(stall), 32'd0);
        check("b2b_done_req", 32'(dmem.dmem_req), 32'd0);
        @(posedge clock);
        #1;
        pc_in = 32'h404; opcode_in = OP_ALU; funct3_in = 3'b000; rd_in = 5'd4; alu_res_in = 32'h77;
        check("b2b_gap_valid", 32'(valid_out), 32'd0);
        @(negedge clock);
        check("b2b_add_stall", 32'(stall), 32'd0);
        check("b2b_add_req", 32'(dmem.dmem_req), 32'd0);
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        check("b2b_add_valid", 32'(valid_out), 32'd1);
        check("b2b_add_wb", wb_data_out, 32'h77);
        check("b2b_add_pc", pc_out, 32'h404);
        check("b2b_add_rw", 32'(reg_write_out), 32'd1);
        @(posedge clock);
        #1;
        check("b2b_end_valid", 32'(valid_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
